// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared decode definitions for the ID stage: opcode/funct encodings,
// immediate-extension modes, destination select and the packed control
// bundle produced by the instruction decoder.
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int OP_W = 6;

   // Primary opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   // R-type function codes with special decode treatment
   localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

   typedef enum logic [1:0] {
      SIGN = 2'd0,
      ZERO = 2'd1,
      LUI  = 2'd2
   } ext_mode_e;

   typedef enum logic {
      DEST_RT = 1'b0,
      DEST_RD = 1'b1
   } dest_sel_e;

   typedef struct packed {
      logic      alu_src;
      logic      reg_write;
      logic      mem_read;
      logic      mem_write;
      logic      branch;
      logic      illegal;
      ext_mode_e ext_mode;
      dest_sel_e dest_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      alu_src:   1'b0,
      reg_write: 1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      branch:    1'b0,
      illegal:   1'b0,
      ext_mode:  SIGN,
      dest_sel:  DEST_RT
   };

   // True when the instruction reads rt as a register operand (not as a
   // destination), so a pending load into rt must stall it.
   function automatic logic uses_rt(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// 2**REGS x NB register file: two asynchronous operand read ports, one
// asynchronous debug read port and one write port gated by the pipeline step.
// Register 0 always reads zero and is never written. All registers clear on
// the asynchronous active-low reset.
// Optional feature macro: ID_WB_BYPASS_EN -- a write in progress is forwarded
// to every read port addressing the same (non-zero) register in that cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   step              write enable gate (0 freezes contents)
//   we, waddr, wdata  write port
//   raddr_a/b, rdata_a/b      operand read ports
//   raddr_dbg, rdata_dbg      debug read port
// -----------------------------------------------------------------------------
module regfile_2r1w #(
   parameter int REGS = 5,
   parameter int NB   = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step,
   input  logic            we,
   input  logic [REGS-1:0] waddr,
   input  logic [NB-1:0]   wdata,
   input  logic [REGS-1:0] raddr_a,
   input  logic [REGS-1:0] raddr_b,
   input  logic [REGS-1:0] raddr_dbg,
   output logic [NB-1:0]   rdata_a,
   output logic [NB-1:0]   rdata_b,
   output logic [NB-1:0]   rdata_dbg
);

   localparam int DEPTH = 2**REGS;

   logic [NB-1:0] mem_r [DEPTH];
   logic          wr_en_s;

   assign wr_en_s = step && we && (waddr != '0);

`ifdef ID_WB_BYPASS_EN
   logic byp_en_s;
   assign byp_en_s = we && (waddr != '0);
`endif

   // Register storage: async clear, step-gated write, r0 never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Operand port A read (r0 forced to zero)
   always_comb begin
      rdata_a = '0;
      if (raddr_a == '0) begin
         rdata_a = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (byp_en_s && (raddr_a == waddr)) begin
         rdata_a = wdata;
`endif
      end else begin
         rdata_a = mem_r[raddr_a];
      end
   end

   // Operand port B read (r0 forced to zero)
   always_comb begin
      rdata_b = '0;
      if (raddr_b == '0) begin
         rdata_b = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (byp_en_s && (raddr_b == waddr)) begin
         rdata_b = wdata;
`endif
      end else begin
         rdata_b = mem_r[raddr_b];
      end
   end

   // Debug port read (r0 forced to zero; independent of step)
   always_comb begin
      rdata_dbg = '0;
      if (raddr_dbg == '0) begin
         rdata_dbg = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (byp_en_s && (raddr_dbg == waddr)) begin
         rdata_dbg = wdata;
`endif
      end else begin
         rdata_dbg = mem_r[raddr_dbg];
      end
   end

endmodule

// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
// MIPS instruction-decode stage with registered ID/EX outputs. Splits the
// instruction into fields, decodes the control set, reads operands from the
// register file (with writeback port), extends the immediate, detects
// load-use hazards and loads the ID/EX register (instruction or bubble).
// Optional feature macro: ID_WB_BYPASS_EN (writeback-to-read forwarding,
// implemented inside regfile_2r1w).
// Ports:
//   i_clk, i_reset (async active-low), i_step (global advance enable)
//   i_valid, i_instruction, i_flush           IF/ID input, squash request
//   i_ex_mem_read, i_ex_rt                     load currently in EX
//   i_wb_we, i_wb_addr, i_wb_data              writeback port
//   i_mips_register_number, o_data_tx_debug    debug read (combinational)
//   o_stall                                    load-use stall (combinational)
//   o_valid ... o_branch                       registered ID/EX contents
// -----------------------------------------------------------------------------
module id_stage_pipelined
   import decode_pkg::*;
#(
   parameter int NB     = 32,
   parameter int REGS   = 5,
   parameter int INBITS = 16,
   parameter int CTRLNB = 6
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_step,
   input  logic              i_valid,
   input  logic [NB-1:0]     i_instruction,
   input  logic              i_flush,
   input  logic              i_ex_mem_read,
   input  logic [REGS-1:0]   i_ex_rt,
   input  logic              i_wb_we,
   input  logic [REGS-1:0]   i_wb_addr,
   input  logic [NB-1:0]     i_wb_data,
   input  logic [REGS-1:0]   i_mips_register_number,
   output logic [NB-1:0]     o_data_tx_debug,
   output logic              o_stall,
   output logic              o_valid,
   output logic              o_illegal,
   output logic [NB-1:0]     o_data_a,
   output logic [NB-1:0]     o_data_b,
   output logic [NB-1:0]     o_extension_result,
   output logic [REGS-1:0]   o_rs,
   output logic [REGS-1:0]   o_rt,
   output logic [REGS-1:0]   o_dest,
   output logic [CTRLNB-1:0] o_intruction_op_code,
   output logic [CTRLNB-1:0] o_intruction_funct_code,
   output logic              o_alu_src,
   output logic              o_reg_write,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_branch
);

   // Instruction fields
   logic [CTRLNB-1:0] op_s;
   logic [CTRLNB-1:0] funct_s;
   logic [REGS-1:0]   rs_s;
   logic [REGS-1:0]   rt_s;
   logic [REGS-1:0]   rd_s;
   logic [INBITS-1:0] imm_s;

   assign op_s    = i_instruction[NB-1 -: CTRLNB];
   assign rs_s    = i_instruction[21 +: REGS];
   assign rt_s    = i_instruction[16 +: REGS];
   assign rd_s    = i_instruction[11 +: REGS];
   assign imm_s   = i_instruction[INBITS-1:0];
   assign funct_s = i_instruction[CTRLNB-1:0];

   ctrl_t           ctrl_s;
   logic [NB-1:0]   ext_s;
   logic [REGS-1:0] dest_s;
   logic [NB-1:0]   rdata_a_s;
   logic [NB-1:0]   rdata_b_s;
   logic            hazard_s;
   logic            bubble_s;

   regfile_2r1w #(
      .REGS (REGS),
      .NB   (NB)
   ) u_regfile (
      .clk       (i_clk),
      .rst_n     (i_reset),
      .step      (i_step),
      .we        (i_wb_we),
      .waddr     (i_wb_addr),
      .wdata     (i_wb_data),
      .raddr_a   (rs_s),
      .raddr_b   (rt_s),
      .raddr_dbg (i_mips_register_number),
      .rdata_a   (rdata_a_s),
      .rdata_b   (rdata_b_s),
      .rdata_dbg (o_data_tx_debug)
   );

   // Control decode from opcode (and funct for JR)
   always_comb begin
      ctrl_s = CTRL_NOP;
      case (op_s)
         OP_RTYPE: begin
            ctrl_s.reg_write = (funct_s != FN_JR);
            ctrl_s.dest_sel  = DEST_RD;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI: begin
            ctrl_s.ext_mode  = SIGN;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            ctrl_s.ext_mode  = ZERO;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_LUI: begin
            ctrl_s.ext_mode  = LUI;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl_s.ext_mode  = SIGN;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_read  = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_SW: begin
            ctrl_s.ext_mode  = SIGN;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_s.ext_mode  = SIGN;
            ctrl_s.branch    = 1'b1;
         end
         default: begin
            ctrl_s.illegal   = 1'b1;
         end
      endcase
   end

   // Immediate extension: sign, zero, or shifted into the upper half (lui)
   always_comb begin
      ext_s = '0;
      case (ctrl_s.ext_mode)
         SIGN:    ext_s = {{(NB-INBITS){imm_s[INBITS-1]}}, imm_s};
         ZERO:    ext_s = {{(NB-INBITS){1'b0}}, imm_s};
         LUI:     ext_s = {imm_s, {(NB-INBITS){1'b0}}};
         default: ext_s = '0;
      endcase
   end

   // Write-address resolution
   always_comb begin
      dest_s = rt_s;
      if (ctrl_s.dest_sel == DEST_RD) begin
         dest_s = rd_s;
      end else begin
         dest_s = rt_s;
      end
   end

   // Load-use hazard: load in EX targets a register this instruction reads.
   // r0 can never be a real dependency. A taken-branch flush masks the
   // request since the dependent instruction is squashed anyway.
   assign hazard_s = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                     ((i_ex_rt == rs_s) || (uses_rt(op_s) && (i_ex_rt == rt_s)));
   assign o_stall  = hazard_s && !i_flush;
   assign bubble_s = i_flush || hazard_s || !i_valid;

   // ID/EX pipeline register: bubble or decoded instruction, frozen when !i_step
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_valid                 <= 1'b0;
         o_illegal               <= 1'b0;
         o_data_a                <= '0;
         o_data_b                <= '0;
         o_extension_result      <= '0;
         o_rs                    <= '0;
         o_rt                    <= '0;
         o_dest                  <= '0;
         o_intruction_op_code    <= '0;
         o_intruction_funct_code <= '0;
         o_alu_src               <= 1'b0;
         o_reg_write             <= 1'b0;
         o_mem_read              <= 1'b0;
         o_mem_write             <= 1'b0;
         o_branch                <= 1'b0;
      end else if (i_step) begin
         if (bubble_s) begin
            o_valid                 <= 1'b0;
            o_illegal               <= 1'b0;
            o_data_a                <= '0;
            o_data_b                <= '0;
            o_extension_result      <= '0;
            o_rs                    <= '0;
            o_rt                    <= '0;
            o_dest                  <= '0;
            o_intruction_op_code    <= '0;
            o_intruction_funct_code <= '0;
            o_alu_src               <= 1'b0;
            o_reg_write             <= 1'b0;
            o_mem_read              <= 1'b0;
            o_mem_write             <= 1'b0;
            o_branch                <= 1'b0;
         end else begin
            o_valid                 <= 1'b1;
            o_illegal               <= ctrl_s.illegal;
            o_data_a                <= rdata_a_s;
            o_data_b                <= rdata_b_s;
            o_extension_result      <= ext_s;
            o_rs                    <= rs_s;
            o_rt                    <= rt_s;
            o_dest                  <= dest_s;
            o_intruction_op_code    <= op_s;
            o_intruction_funct_code <= funct_s;
            o_alu_src               <= ctrl_s.alu_src;
            o_reg_write             <= ctrl_s.reg_write;
            o_mem_read              <= ctrl_s.mem_read;
            o_mem_write             <= ctrl_s.mem_write;
            o_branch                <= ctrl_s.branch;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipelined
// Directed self-checking bench for id_stage_pipelined. Inputs change 1 time
// unit after the rising edge; registered outputs are sampled at that point,
// combinational outputs after a further settling delay.
// -----------------------------------------------------------------------------
module tb_id_stage_pipelined;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_step;
   logic        i_valid;
   logic [31:0] i_instruction;
   logic        i_flush;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rt;
   logic        i_wb_we;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic [4:0]  i_mips_register_number;
   logic [31:0] o_data_tx_debug;
   logic        o_stall;
   logic        o_valid;
   logic        o_illegal;
   logic [31:0] o_data_a;
   logic [31:0] o_data_b;
   logic [31:0] o_extension_result;
   logic [4:0]  o_rs;
   logic [4:0]  o_rt;
   logic [4:0]  o_dest;
   logic [5:0]  o_intruction_op_code;
   logic [5:0]  o_intruction_funct_code;
   logic        o_alu_src;
   logic        o_reg_write;
   logic        o_mem_read;
   logic        o_mem_write;
   logic        o_branch;

   int n_checks = 0;
   int n_fails  = 0;

   id_stage_pipelined dut (
      .i_clk                   (i_clk),
      .i_reset                 (i_reset),
      .i_step                  (i_step),
      .i_valid                 (i_valid),
      .i_instruction           (i_instruction),
      .i_flush                 (i_flush),
      .i_ex_mem_read           (i_ex_mem_read),
      .i_ex_rt                 (i_ex_rt),
      .i_wb_we                 (i_wb_we),
      .i_wb_addr               (i_wb_addr),
      .i_wb_data               (i_wb_data),
      .i_mips_register_number  (i_mips_register_number),
      .o_data_tx_debug         (o_data_tx_debug),
      .o_stall                 (o_stall),
      .o_valid                 (o_valid),
      .o_illegal               (o_illegal),
      .o_data_a                (o_data_a),
      .o_data_b                (o_data_b),
      .o_extension_result      (o_extension_result),
      .o_rs                    (o_rs),
      .o_rt                    (o_rt),
      .o_dest                  (o_dest),
      .o_intruction_op_code    (o_intruction_op_code),
      .o_intruction_funct_code (o_intruction_funct_code),
      .o_alu_src               (o_alu_src),
      .o_reg_write             (o_reg_write),
      .o_mem_read              (o_mem_read),
      .o_mem_write             (o_mem_write),
      .o_branch                (o_branch)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset = 1'b0;
      i_step = 1'b1;
      i_valid = 1'b0;
      i_instruction = 32'h0000_0000;
      i_flush = 1'b0;
      i_ex_mem_read = 1'b0;
      i_ex_rt = 5'd0;
      i_wb_we = 1'b0;
      i_wb_addr = 5'd0;
      i_wb_data = 32'h0000_0000;
      i_mips_register_number = 5'd5;

      // Reset state
      #1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_data_a", o_data_a, 32'd0);
      chk("rst_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("rst_dbg_r5", o_data_tx_debug, 32'd0);
      #2 i_reset = 1'b1;

      // Writeback r5 = 0xAA, no instruction
      i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h0000_00AA;
      tick();
      chk("wb_bubble_valid", {31'd0, o_valid}, 32'd0);
      chk("dbg_r5_written", o_data_tx_debug, 32'h0000_00AA);

      // add r3,r5,r0
      i_wb_we = 1'b0;
      i_valid = 1'b1; i_instruction = rtype(5'd5, 5'd0, 5'd3, 6'b100000);
      tick();
      chk("add_data_a", o_data_a, 32'h0000_00AA);
      chk("add_data_b", o_data_b, 32'd0);
      chk("add_dest", {27'd0, o_dest}, 32'd3);
      chk("add_regwr", {31'd0, o_reg_write}, 32'd1);
      chk("add_valid", {31'd0, o_valid}, 32'd1);
      chk("add_alusrc", {31'd0, o_alu_src}, 32'd0);
      chk("add_funct", {26'd0, o_intruction_funct_code}, 32'h20);
      chk("add_rs", {27'd0, o_rs}, 32'd5);

      // addi r2,r1,-1
      i_instruction = itype(6'b001000, 5'd1, 5'd2, 16'hFFFF);
      tick();
      chk("addi_ext", o_extension_result, 32'hFFFF_FFFF);
      chk("addi_dest", {27'd0, o_dest}, 32'd2);
      chk("addi_alusrc", {31'd0, o_alu_src}, 32'd1);
      chk("addi_op", {26'd0, o_intruction_op_code}, 32'h08);

      // ori r4,r0,0xFFFF
      i_instruction = itype(6'b001101, 5'd0, 5'd4, 16'hFFFF);
      tick();
      chk("ori_ext", o_extension_result, 32'h0000_FFFF);
      chk("ori_regwr", {31'd0, o_reg_write}, 32'd1);

      // lui r8,0x1234
      i_instruction = itype(6'b001111, 5'd0, 5'd8, 16'h1234);
      tick();
      chk("lui_ext", o_extension_result, 32'h1234_0000);
      chk("lui_dest", {27'd0, o_dest}, 32'd8);

      // lw r4,0(r5)
      i_instruction = itype(6'b100011, 5'd5, 5'd4, 16'h0000);
      tick();
      chk("lw_memrd", {31'd0, o_mem_read}, 32'd1);
      chk("lw_regwr", {31'd0, o_reg_write}, 32'd1);
      chk("lw_dest", {27'd0, o_dest}, 32'd4);
      chk("lw_data_a", o_data_a, 32'h0000_00AA);

      // Load-use: sub r6,r7,r4 with load into r4 in EX
      i_ex_mem_read = 1'b1; i_ex_rt = 5'd4;
      i_instruction = rtype(5'd7, 5'd4, 5'd6, 6'b100010);
      #1 chk("lu_stall", {31'd0, o_stall}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'd0, o_valid}, 32'd0);
      chk("lu_bubble_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("lu_bubble_memrd", {31'd0, o_mem_read}, 32'd0);
      i_ex_mem_read = 1'b0;
      #1 chk("lu_release", {31'd0, o_stall}, 32'd0);
      tick();
      chk("lu_issue_valid", {31'd0, o_valid}, 32'd1);
      chk("lu_issue_dest", {27'd0, o_dest}, 32'd6);
      chk("lu_issue_funct", {26'd0, o_intruction_funct_code}, 32'h22);

      // Hazard corner cases (combinational only)
      i_ex_mem_read = 1'b1; i_ex_rt = 5'd4;
      i_instruction = itype(6'b001000, 5'd4, 5'd2, 16'h0001);
      #1 chk("hz_rs_match", {31'd0, o_stall}, 32'd1);
      i_instruction = itype(6'b001101, 5'd1, 5'd4, 16'h0001);
      #1 chk("hz_rt_not_used", {31'd0, o_stall}, 32'd0);
      i_ex_rt = 5'd0;
      i_instruction = rtype(5'd0, 5'd0, 5'd6, 6'b100000);
      #1 chk("hz_r0", {31'd0, o_stall}, 32'd0);
      i_ex_rt = 5'd4;
      i_valid = 1'b0;
      i_instruction = rtype(5'd4, 5'd4, 5'd6, 6'b100000);
      #1 chk("hz_invalid", {31'd0, o_stall}, 32'd0);
      i_ex_mem_read = 1'b0; i_ex_rt = 5'd0;
      i_valid = 1'b1;

      // Write to r0 alongside add r3,r5,r0
      i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h0000_DEAD;
      i_instruction = rtype(5'd5, 5'd0, 5'd3, 6'b100000);
      tick();
      i_wb_we = 1'b0;
      i_mips_register_number = 5'd0;
      #1;
      chk("r0_dbg", o_data_tx_debug, 32'd0);
      chk("r0_valid", {31'd0, o_valid}, 32'd1);
      i_instruction = rtype(5'd0, 5'd0, 5'd3, 6'b100000);
      tick();
      chk("r0_read_a", o_data_a, 32'd0);

      // Flush together with a stall condition
      i_flush = 1'b1; i_ex_mem_read = 1'b1; i_ex_rt = 5'd4;
      i_instruction = rtype(5'd7, 5'd4, 5'd6, 6'b100010);
      #1 chk("flush_stall_low", {31'd0, o_stall}, 32'd0);
      tick();
      chk("flush_valid", {31'd0, o_valid}, 32'd0);
      chk("flush_regwr", {31'd0, o_reg_write}, 32'd0);
      i_flush = 1'b0; i_ex_mem_read = 1'b0; i_ex_rt = 5'd0;

      // Freeze: load add r1,r5,r5 then hold i_step=0 for 3 cycles with WB active
      i_instruction = rtype(5'd5, 5'd5, 5'd1, 6'b100000);
      tick();
      chk("pre_freeze_b", o_data_b, 32'h0000_00AA);
      i_step = 1'b0;
      i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h0000_0055;
      i_instruction = itype(6'b001101, 5'd0, 5'd4, 16'hFFFF);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("freeze_data_a", o_data_a, 32'h0000_00AA);
         chk("freeze_dest", {27'd0, o_dest}, 32'd1);
         chk("freeze_alusrc", {31'd0, o_alu_src}, 32'd0);
      end
      i_wb_we = 1'b0;
      i_mips_register_number = 5'd5;
      #1 chk("freeze_rf_r5", o_data_tx_debug, 32'h0000_00AA);
      i_step = 1'b1;
      i_instruction = rtype(5'd5, 5'd0, 5'd1, 6'b100000);
      tick();
      chk("post_freeze_a", o_data_a, 32'h0000_00AA);

      // Illegal opcode
      i_instruction = itype(6'b111111, 5'd1, 5'd2, 16'h0003);
      tick();
      chk("ill_flag", {31'd0, o_illegal}, 32'd1);
      chk("ill_valid", {31'd0, o_valid}, 32'd1);
      chk("ill_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("ill_alusrc", {31'd0, o_alu_src}, 32'd0);

      // beq r5,r5,-2
      i_instruction = itype(6'b000100, 5'd5, 5'd5, 16'hFFFE);
      tick();
      chk("beq_branch", {31'd0, o_branch}, 32'd1);
      chk("beq_ext", o_extension_result, 32'hFFFF_FFFE);
      chk("beq_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("beq_illegal", {31'd0, o_illegal}, 32'd0);

      // sw r5,8(r0)
      i_instruction = itype(6'b101011, 5'd0, 5'd5, 16'h0008);
      tick();
      chk("sw_memwr", {31'd0, o_mem_write}, 32'd1);
      chk("sw_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("sw_data_b", o_data_b, 32'h0000_00AA);

      // jr r5
      i_instruction = rtype(5'd5, 5'd0, 5'd0, 6'b001000);
      tick();
      chk("jr_regwr", {31'd0, o_reg_write}, 32'd0);
      chk("jr_valid", {31'd0, o_valid}, 32'd1);

      // Same-cycle WB to r9 with add r1,r9,r9
      i_wb_we = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h1234_5678;
      i_instruction = rtype(5'd9, 5'd9, 5'd1, 6'b100000);
      tick();
`ifdef ID_WB_BYPASS_EN
      chk("rdw_a", o_data_a, 32'h1234_5678);
      chk("rdw_b", o_data_b, 32'h1234_5678);
`else
      chk("rdw_a", o_data_a, 32'h0000_0000);
      chk("rdw_b", o_data_b, 32'h0000_0000);
`endif
      i_wb_we = 1'b0;
      tick();
      chk("after_wb_a", o_data_a, 32'h1234_5678);

      // Asynchronous reset mid-cycle clears everything
      #2 i_reset = 1'b0;
      i_mips_register_number = 5'd9;
      #1;
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_data_a", o_data_a, 32'd0);
      chk("arst_dbg_r9", o_data_tx_debug, 32'd0);
      i_reset = 1'b1;
      tick();
      chk("arst_reload_a", o_data_a, 32'd0);
      chk("arst_reload_valid", {31'd0, o_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised, registered instruction-decode stage for the MIPS pipeline. It splits the instruction word into fields and decodes the full control set. It holds a 2-read / 1-write / 1-debug register file with a writeback port, extends immediates in three modes, detects load-use hazards and stalls, and latches everything into the ID/EX pipeline register. It sits between IF/ID and EX, and the debug unit observes it through `i_step` and the debug read port.

## Interface
- NB, 32: datapath and instruction width
- REGS, 5: register address width; register count is 2**REGS
- INBITS, 16: immediate field width
- CTRLNB, 6: opcode/funct width
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  pipeline advance enable; 0 freezes all state, including register-file writes
- i_valid  in  1  IF/ID holds a real instruction
- i_instruction  in  NB  instruction word
- i_flush  in  1  squash the instruction entering ID/EX (branch resolved taken)
- i_ex_mem_read, i_ex_rt  in  1, REGS  load currently in EX and its destination
- i_wb_we, i_wb_addr, i_wb_data  in  1, REGS, NB  writeback port
- i_mips_register_number  in  REGS  debug read address
- o_data_tx_debug  out  NB  debug read data, combinational; address 0 reads 0
- o_stall  out  1  combinational load-use stall request to IF/PC
- o_valid, o_illegal  out  1 each  ID/EX valid; unknown opcode latched
- o_data_a, o_data_b, o_extension_result  out  NB  registered operands and immediate
- o_rs, o_rt, o_dest  out  REGS  source addresses and resolved write address
- o_intruction_op_code, o_intruction_funct_code  out  CTRLNB  registered fields
- o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_branch  out  1 each  registered controls

## Operation
- Fields: op [NB-1:NB-CTRLNB]; rs [25:21]; rt [20:16]; rd [15:11]; imm [INBITS-1:0]; funct [CTRLNB-1:0].
- Decode:
  - R-type 000000: reg_write, dest=rd; funct 001000 (JR) clears reg_write.
  - addi/addiu/slti 001000/001001/001010: sign-extend, alu_src, reg_write, dest=rt.
  - andi/ori/xori 001100/001101/001110: zero-extend, alu_src, reg_write, dest=rt.
  - lui 001111: imm<<16, alu_src, reg_write, dest=rt.
  - lw 100011: sign-extend, alu_src, mem_read, reg_write, dest=rt.
  - sw 101011: sign-extend, alu_src, mem_write; reads rt.
  - beq/bne 000100/000101: branch, sign-extend; reads rt.
  - Any other opcode: all controls 0, illegal=1.
- uses_rt = R-type, sw, beq or bne.
- Register file:
  - Register 0 always reads 0.
  - Write occurs on a clock edge when i_step && i_wb_we && i_wb_addr!=0.
- Hazard: stall = i_valid && i_ex_mem_read && i_ex_rt!=0 && (i_ex_rt==rs || (uses_rt && i_ex_rt==rt)).
- ID/EX update when i_step=1:
  - i_flush: load a bubble (valid=0, all controls 0). Flush beats stall.
  - Else stall or !i_valid: load a bubble.
  - Else load the decoded instruction with valid=1.
- o_stall is held 0 while i_flush=1.

## Timing
- Reset: every registered output is 0, and all 2**REGS registers are cleared. It takes effect immediately, even mid-stall or mid-write.
- Latency: an instruction presented in cycle N appears on the ID/EX outputs after edge N+1.
- o_stall and o_data_tx_debug are combinational from the current inputs; the debug port ignores i_step.
- A load-use stall inserts exactly one bubble. On the next cycle the load has left EX, the external i_ex_mem_read drops, and o_stall deasserts.
- Read-during-write behaviour depends on the macro in Configuration.

## Configuration
- ID_WB_BYPASS_EN defined: when i_wb_we && i_wb_addr!=0 && i_wb_addr matches rs or rt, the operand equals i_wb_data in the same cycle. The debug port also bypasses.
- ID_WB_BYPASS_EN undefined: reads return the pre-write content. Software inserts a nop between writeback and a dependent read.

## Structure
- Package decode_pkg holds:
  - Opcode and funct localparams.
  - Extension-mode enum: SIGN, ZERO, LUI.
  - A packed control struct: alu_src, reg_write, mem_read, mem_write, branch, illegal, ext_mode, dest_sel.
- Sub-module regfile_2r1w (REGS, NB): two async read ports, a debug read port, one write port with step gating, an optional bypass and async clear.
- Decode, hazard logic and the ID/EX register are written in id_stage_pipelined.

## Test plan
- Reset released, then write 0x0000_00AA to r5 via WB. Next cycle, `add r3,r5,r0` -> o_data_a=0xAA, o_dest=3, o_reg_write=1, o_valid=1.
- `addi r2,r1,-1` (imm 0xFFFF) -> o_extension_result=0xFFFF_FFFF.
- `ori` with imm 0xFFFF -> o_extension_result=0x0000_FFFF.
- `lui` with imm 0x1234 -> o_extension_result=0x1234_0000.
- i_ex_mem_read=1 with i_ex_rt=4, then `sub r6,r7,r4` -> o_stall=1 and one bubble (o_valid=0, controls 0). The next cycle issues normally.
- Write to r0 with data 0xDEAD, or i_flush=1 together with a stall condition:
  - The r0 read stays 0.
  - The flushed bubble is loaded and o_stall=0.
- i_step=0 for 3 cycles with WB active -> outputs hold and the register file is unchanged. With ID_WB_BYPASS_EN, a same-cycle WB to r9 and `add r1,r9,r9` -> o_data_a=o_data_b=i_wb_data.
